// File: rtl/ts_symbol_pack_fifo_pkg.sv
// Shared constants and helpers for the TS symbol packing FIFO.
// Holds default symbol/word widths, the lane-to-bit-position mapping and a
// ceiling-log2 helper usable in constant expressions.
package ts_pkg;

    localparam int TS_SYM_W  = 10;
    localparam int TS_WORD_W = 32;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int ts_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // MSB bit index of a lane; lane 0 sits in the top bits of the word.
    function automatic int lane_msb(input int lane, input int word_w, input int sym_w);
        return word_w - 1 - lane * sym_w;
    endfunction

endpackage

// File: rtl/ts_symbol_pack_fifo_if.sv
// Write/read handshake and status bundle of the TS symbol packing FIFO.
// master = symbol producer/consumer, slave = the FIFO itself.
interface ts_symbol_pack_fifo_if
    import ts_pkg::*;
#(
    parameter int SYM_W = TS_SYM_W,
    parameter int CNT_W = 6
);
    logic             WR_EN;
    logic [SYM_W-1:0] WR_DATA;
    logic             RD_EN;
    logic [SYM_W-1:0] RD_DATA;
    logic             RD_VALID;
    logic             FULL;
    logic             EMPTY;
    logic [CNT_W-1:0] LEVEL;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output WR_EN, WR_DATA, RD_EN,
        input  RD_DATA, RD_VALID, FULL, EMPTY, LEVEL, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_EN, WR_DATA, RD_EN,
        output RD_DATA, RD_VALID, FULL, EMPTY, LEVEL, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/ts_symbol_pack_fifo_ptr.sv
// Word/lane pointer pair for the packing FIFO. The lane steps through the
// SPW symbols of a word; after the last lane the word pointer moves on and
// wraps DEPTH-1 -> 0 (DEPTH need not be a power of two).
module ts_pack_ptr
    import ts_pkg::*;
#(
    parameter  int SPW    = 3,
    parameter  int DEPTH  = 21,
    localparam int PTR_W  = (DEPTH > 1) ? ts_clog2(DEPTH) : 1,
    localparam int LANE_W = (SPW > 1) ? ts_clog2(SPW) : 1
)
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ADVANCE,
    output logic [PTR_W-1:0]  WORD_PTR,
    output logic [LANE_W-1:0] LANE
);

    logic [PTR_W-1:0]  ptr_r;
    logic [LANE_W-1:0] lane_r;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [LANE_W-1:0] lane_nxt_s;

    // Next pointer: step the lane, roll into the next word after the last lane.
    always_comb begin
        ptr_nxt_s  = ptr_r;
        lane_nxt_s = lane_r;
        if (ADVANCE) begin
            if (lane_r == LANE_W'(SPW - 1)) begin
                lane_nxt_s = {LANE_W{1'b0}};
                if (ptr_r == PTR_W'(DEPTH - 1)) begin
                    ptr_nxt_s = {PTR_W{1'b0}};
                end else begin
                    ptr_nxt_s = ptr_r + PTR_W'(1);
                end
            end else begin
                lane_nxt_s = lane_r + LANE_W'(1);
            end
        end else begin
            ptr_nxt_s  = ptr_r;
            lane_nxt_s = lane_r;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            ptr_r  <= {PTR_W{1'b0}};
            lane_r <= {LANE_W{1'b0}};
        end else begin
            ptr_r  <= ptr_nxt_s;
            lane_r <= lane_nxt_s;
        end
    end

    assign WORD_PTR = ptr_r;
    assign LANE     = lane_r;

endmodule

// File: rtl/ts_symbol_pack_fifo.sv
// Circular FIFO packing SYM_W-bit TS symbols into WORD_W-bit storage words
// (first symbol in the MSB lane) and unpacking them on read. Write and read
// may both be accepted in one cycle; status and error flags are registered.
module ts_symbol_pack_fifo
    import ts_pkg::*;
#(
    parameter int SYM_W  = TS_SYM_W,
    parameter int WORD_W = TS_WORD_W,
    parameter int DEPTH  = 21
)
(
    input  logic CLOCK,
    input  logic RESET,
    ts_symbol_pack_fifo_if.slave bus
);

    localparam int SPW    = WORD_W / SYM_W;
    localparam int CAP    = DEPTH * SPW;
    localparam int CNT_W  = ts_clog2(DEPTH * SPW + 1);
    localparam int PTR_W  = (DEPTH > 1) ? ts_clog2(DEPTH) : 1;
    localparam int LANE_W = (SPW > 1) ? ts_clog2(SPW) : 1;
    localparam int PAD_W  = WORD_W - SPW * SYM_W;
    // Low pad bits below the last lane; cleared whenever lane 0 is written.
    localparam logic [WORD_W-1:0] PAD_MASK =
        (PAD_W > 0) ? ((WORD_W'(1'b1) << PAD_W) - WORD_W'(1'b1)) : {WORD_W{1'b0}};

    logic [WORD_W-1:0] mem_r [0:DEPTH-1];

    logic [PTR_W-1:0]  wr_ptr_s;
    logic [LANE_W-1:0] wr_lane_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic [LANE_W-1:0] rd_lane_s;

    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [SYM_W-1:0]  rd_sym_s;
    logic [CNT_W-1:0]  level_nxt_s;

    logic [CNT_W-1:0]  level_r;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic [SYM_W-1:0]  rd_data_r;
    logic              rd_valid_r;

    // A read needs data already stored; a write into a full FIFO is only
    // taken when a read frees a slot in the same cycle. Reset-cycle ops are dropped.
    assign rd_acc_s = RESET & bus.RD_EN & ~empty_r;
    assign wr_acc_s = RESET & bus.WR_EN & (~full_r | rd_acc_s);

    ts_pack_ptr #(.SPW(SPW), .DEPTH(DEPTH)) u_wr_ptr (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .ADVANCE  (wr_acc_s),
        .WORD_PTR (wr_ptr_s),
        .LANE     (wr_lane_s)
    );

    ts_pack_ptr #(.SPW(SPW), .DEPTH(DEPTH)) u_rd_ptr (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .ADVANCE  (rd_acc_s),
        .WORD_PTR (rd_ptr_s),
        .LANE     (rd_lane_s)
    );

    // Merge the incoming symbol into its lane of the current write word.
    always_comb begin
        wr_word_s = mem_r[wr_ptr_s];
        if (wr_lane_s == LANE_W'(0)) begin
            wr_word_s = wr_word_s & ~PAD_MASK;
        end else begin
            wr_word_s = wr_word_s;
        end
        for (int l = 0; l < SPW; l++) begin
            if (wr_lane_s == LANE_W'(l)) begin
                wr_word_s[lane_msb(l, WORD_W, SYM_W) -: SYM_W] = bus.WR_DATA;
            end else begin
                wr_word_s = wr_word_s;
            end
        end
    end

    // Storage word update; contents are deliberately not reset.
    always_ff @(posedge CLOCK) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_s] <= wr_word_s;
        end
    end

    // Select the read lane out of the current read word (pre-write contents).
    always_comb begin
        rd_word_s = mem_r[rd_ptr_s];
        rd_sym_s  = {SYM_W{1'b0}};
        for (int l = 0; l < SPW; l++) begin
            if (rd_lane_s == LANE_W'(l)) begin
                rd_sym_s = rd_word_s[lane_msb(l, WORD_W, SYM_W) -: SYM_W];
            end else begin
                rd_sym_s = rd_sym_s;
            end
        end
    end

    // Level moves only when exactly one of write/read is accepted.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + CNT_W'(1);
            2'b01:   level_nxt_s = level_r - CNT_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Level, full/empty and sticky error flags.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            level_r     <= {CNT_W{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            level_r     <= level_nxt_s;
            full_r      <= (level_nxt_s == CNT_W'(CAP));
            empty_r     <= (level_nxt_s == CNT_W'(0));
            overflow_r  <= overflow_r | (bus.WR_EN & ~wr_acc_s);
            underflow_r <= underflow_r | (bus.RD_EN & ~rd_acc_s);
        end
    end

    // Read data register: loads on an accepted read, otherwise holds.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            rd_data_r  <= {SYM_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
            rd_data_r  <= rd_sym_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end
    end

    assign bus.RD_DATA   = rd_data_r;
    assign bus.RD_VALID  = rd_valid_r;
    assign bus.FULL      = full_r;
    assign bus.EMPTY     = empty_r;
    assign bus.LEVEL     = level_r;
    assign bus.OVERFLOW  = overflow_r;
    assign bus.UNDERFLOW = underflow_r;

endmodule

// File: tb/tb_ts_symbol_pack_fifo.sv
// Testbench for ts_symbol_pack_fifo: two instances (default 10/32/21 and
// 8/32/5), a queue model of stored symbols and a scoreboard of expected
// read data, checked every cycle just after the rising edge.
`timescale 1ns/1ps
module tb_ts_symbol_pack_fifo;

    localparam int A_CAP   = 63;
    localparam int A_CNT_W = 6;
    localparam int B_CAP   = 20;
    localparam int B_CNT_W = 5;

    logic CLOCK;
    logic RESET;

    int n_checks;
    int n_errors;

    logic [9:0] mdl_a_q[$];
    logic [9:0] exp_a_q[$];
    logic [7:0] mdl_b_q[$];
    logic [7:0] exp_b_q[$];
    bit         ovf_a, unf_a, vld_a;
    bit         ovf_b, unf_b, vld_b;
    logic [9:0] last_a;
    logic [7:0] last_b;

    ts_symbol_pack_fifo_if #(.SYM_W(10), .CNT_W(A_CNT_W)) bus_a ();
    ts_symbol_pack_fifo_if #(.SYM_W(8),  .CNT_W(B_CNT_W)) bus_b ();

    ts_symbol_pack_fifo #(.SYM_W(10), .WORD_W(32), .DEPTH(21)) dut_a (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus_a)
    );

    ts_symbol_pack_fifo #(.SYM_W(8), .WORD_W(32), .DEPTH(5)) dut_b (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus_b)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive both DUTs, update the model, then check after the edge.
    task automatic cyc(input bit rst, input bit wa, input logic [9:0] da, input bit ra,
                       input bit wb, input logic [7:0] db, input bit rb);
        bit ra_ok, wa_ok, rb_ok, wb_ok;
        RESET         = ~rst;
        bus_a.WR_EN   = wa;
        bus_a.WR_DATA = da;
        bus_a.RD_EN   = ra;
        bus_b.WR_EN   = wb;
        bus_b.WR_DATA = db;
        bus_b.RD_EN   = rb;
        if (rst) begin
            mdl_a_q.delete(); exp_a_q.delete();
            mdl_b_q.delete(); exp_b_q.delete();
            ovf_a = 1'b0; unf_a = 1'b0; vld_a = 1'b0; last_a = 10'h000;
            ovf_b = 1'b0; unf_b = 1'b0; vld_b = 1'b0; last_b = 8'h00;
        end else begin
            ra_ok = ra && (mdl_a_q.size() > 0);
            wa_ok = wa && ((mdl_a_q.size() < A_CAP) || ra_ok);
            if (ra_ok) exp_a_q.push_back(mdl_a_q.pop_front());
            if (wa_ok) mdl_a_q.push_back(da);
            if (wa && !wa_ok) ovf_a = 1'b1;
            if (ra && !ra_ok) unf_a = 1'b1;
            vld_a = ra_ok;
            rb_ok = rb && (mdl_b_q.size() > 0);
            wb_ok = wb && ((mdl_b_q.size() < B_CAP) || rb_ok);
            if (rb_ok) exp_b_q.push_back(mdl_b_q.pop_front());
            if (wb_ok) mdl_b_q.push_back(db);
            if (wb && !wb_ok) ovf_b = 1'b1;
            if (rb && !rb_ok) unf_b = 1'b1;
            vld_b = rb_ok;
        end
        @(posedge CLOCK);
        #1;
        check_val("a_valid", bus_a.RD_VALID, vld_a);
        if (bus_a.RD_VALID && exp_a_q.size() > 0) last_a = exp_a_q.pop_front();
        check_val("a_data", bus_a.RD_DATA, last_a);
        check_val("a_level", bus_a.LEVEL, mdl_a_q.size());
        check_val("a_full", bus_a.FULL, mdl_a_q.size() == A_CAP);
        check_val("a_empty", bus_a.EMPTY, mdl_a_q.size() == 0);
        check_val("a_ovf", bus_a.OVERFLOW, ovf_a);
        check_val("a_unf", bus_a.UNDERFLOW, unf_a);
        check_val("b_valid", bus_b.RD_VALID, vld_b);
        if (bus_b.RD_VALID && exp_b_q.size() > 0) last_b = exp_b_q.pop_front();
        check_val("b_data", bus_b.RD_DATA, last_b);
        check_val("b_level", bus_b.LEVEL, mdl_b_q.size());
        check_val("b_full", bus_b.FULL, mdl_b_q.size() == B_CAP);
        check_val("b_empty", bus_b.EMPTY, mdl_b_q.size() == 0);
        check_val("b_ovf", bus_b.OVERFLOW, ovf_b);
        check_val("b_unf", bus_b.UNDERFLOW, unf_b);
        RESET = 1'b1;
    endtask

    task automatic cyc_a(input bit wa, input logic [9:0] da, input bit ra);
        cyc(1'b0, wa, da, ra, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic cyc_b(input bit wb, input logic [7:0] db, input bit rb);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, wb, db, rb);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [31:0] word0_exp;
        n_checks = 0;
        n_errors = 0;
        RESET    = 1'b0;

        // Reset state
        do_reset();
        do_reset();

        // 1: three writes packed into word 0, then three reads
        cyc_a(1'b1, 10'h3A1, 1'b0);
        cyc_a(1'b1, 10'h2B2, 1'b0);
        cyc_a(1'b1, 10'h1C3, 1'b0);
        word0_exp = {10'h3A1, 10'h2B2, 10'h1C3, 2'b00};
        check_val("t1_word0", dut_a.mem_r[0], word0_exp);
        for (int i = 0; i < 3; i++) cyc_a(1'b0, 10'h000, 1'b1);
        cyc_a(1'b0, 10'h000, 1'b0);

        // 2: fill to capacity, one rejected write, full readout
        for (int i = 0; i < A_CAP; i++) cyc_a(1'b1, 10'($urandom), 1'b0);
        cyc_a(1'b1, 10'h155, 1'b0);
        for (int i = 0; i < A_CAP; i++) cyc_a(1'b0, 10'h000, 1'b1);

        // 3: read on empty, then write+read on empty (no fall-through)
        cyc_a(1'b0, 10'h000, 1'b1);
        cyc_a(1'b1, 10'h2AA, 1'b1);
        cyc_a(1'b0, 10'h000, 1'b1);

        // 4: full FIFO with simultaneous write+read stream across pointer wrap
        do_reset();
        for (int i = 0; i < A_CAP; i++) cyc_a(1'b1, 10'($urandom), 1'b0);
        for (int i = 0; i < 200; i++) cyc_a(1'b1, 10'($urandom), 1'b1);
        for (int i = 0; i < A_CAP; i++) cyc_a(1'b0, 10'h000, 1'b1);

        // 5: reset in mid-stream with a write presented
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 10'($urandom), 1'b0);
        cyc_a(1'b0, 10'h000, 1'b1);
        cyc(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc_a(1'b1, 10'h0F0, 1'b0);
        cyc_a(1'b0, 10'h000, 1'b1);
        cyc_a(1'b0, 10'h000, 1'b0);

        // 6: 8-bit symbols, 4 per word, 5 words: random streams and overfill
        do_reset();
        for (int i = 0; i < 60; i++)
            cyc_b(1'b1, 8'($urandom), ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 150; i++)
            cyc_b(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1));
        for (int i = 0; i < B_CAP + 3; i++) cyc_b(1'b0, 8'h00, 1'b1);

        check_val("a_sb_drain", exp_a_q.size(), 0);
        check_val("b_sb_drain", exp_b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
